// File: rtl/seg_capture_encoder.sv
// seg_capture_encoder: monitors a multiplexed active-low 7-segment bus and recovers the 5-bit
// character code shown on each of four digits, publishing whole frames with a one-cycle strobe.
// Optional feature macro: SEGCAP_GLITCH_FILTER_EN enables the STABLE_CYCLES stability filter;
// when undefined, a digit is captured on the first sample of each new valid (anode, LED) pair.
module seg_capture_encoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [6:0]  LED,
    output logic [19:0] chars,
    output logic [3:0]  err,
    output logic        frame_valid
);

    typedef enum logic [1:0] {StIdle, StTrack, StHeld} state_t;

    state_t      state_q, state_d;
    logic [1:0]  idx_q;
    logic [6:0]  led_q;
    logic [19:0] slot_chars_q, slot_chars_d;
    logic [3:0]  slot_err_q, slot_err_d;
    logic [3:0]  seen_q, seen_next;

    logic        sel_valid;
    logic [1:0]  sel_idx;
    logic        same_pair;
    logic        capture;
    logic [4:0]  enc_code;
    logic        enc_err;

    // Returns {err, code}; aliases already resolve to the lowest code, so one entry each.
    function automatic logic [5:0] encode(input logic [6:0] p);
        logic [5:0] r;
        case (p)
            7'b1000000: r = {1'b0, 5'd0};
            7'b1111001: r = {1'b0, 5'd1};
            7'b0100100: r = {1'b0, 5'd2};
            7'b0110000: r = {1'b0, 5'd3};
            7'b0011001: r = {1'b0, 5'd4};
            7'b0010010: r = {1'b0, 5'd5};
            7'b0000011: r = {1'b0, 5'd6};
            7'b1111000: r = {1'b0, 5'd7};
            7'b0000000: r = {1'b0, 5'd8};
            7'b0011000: r = {1'b0, 5'd9};
            7'b0001000: r = {1'b0, 5'd10};
            7'b1000110: r = {1'b0, 5'd12};
            7'b0000110: r = {1'b0, 5'd14};
            7'b0001110: r = {1'b0, 5'd15};
            7'b0000010: r = {1'b0, 5'd16};
            7'b0001001: r = {1'b0, 5'd17};
            7'b1110000: r = {1'b0, 5'd19};
            7'b1000111: r = {1'b0, 5'd21};
            7'b0001100: r = {1'b0, 5'd25};
            7'b1000001: r = {1'b0, 5'd30};
            default:    r = {1'b1, 5'd0};
        endcase
        return r;
    endfunction

    // Decode the anode bus: a sample counts only when exactly one digit is selected.
    always_comb begin
        sel_valid = 1'b1;
        sel_idx   = 2'd0;
        case (an)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: sel_valid = 1'b0;
        endcase
    end

    assign same_pair = (state_q != StIdle) && sel_valid && (sel_idx == idx_q) && (LED == led_q);
    assign {enc_err, enc_code} = encode(LED);

`ifdef SEGCAP_GLITCH_FILTER_EN
    localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);

    logic [7:0] count_q, count_d;

    // Tracking FSM with stability counter; count saturates at StableCnt while held.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        capture = 1'b0;
        if (!sel_valid) begin
            state_d = StIdle;
            count_d = 8'd0;
        end else if (same_pair) begin
            if (state_q == StTrack) begin
                count_d = count_q + 8'd1;
                if (count_d == StableCnt) begin
                    capture = 1'b1;
                    state_d = StHeld;
                end
            end
        end else begin
            state_d = StTrack;
            count_d = 8'd1;
            if (StableCnt == 8'd1) begin
                capture = 1'b1;
                state_d = StHeld;
            end
        end
    end

    // Stability counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^STABLE_CYCLES;

    // Unfiltered FSM: any new valid pair is captured immediately.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        if (!sel_valid) begin
            state_d = StIdle;
        end else if (!same_pair) begin
            capture = 1'b1;
            state_d = StHeld;
        end
    end
`endif

    // Next slot contents and seen mask for a capture on the current edge.
    always_comb begin
        slot_chars_d = slot_chars_q;
        slot_err_d   = slot_err_q;
        seen_next    = seen_q;
        for (int i = 0; i < 4; i++) begin
            if (sel_idx == 2'(i)) begin
                slot_chars_d[5*i +: 5] = enc_code;
                slot_err_d[i]          = enc_err;
                seen_next[i]           = 1'b1;
            end
        end
    end

    // FSM state and previous-sample registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            idx_q   <= 2'd0;
            led_q   <= 7'd0;
        end else begin
            state_q <= state_d;
            if (sel_valid) begin
                idx_q <= sel_idx;
                led_q <= LED;
            end
        end
    end

    // Slot capture and frame publication; a frame completes when every digit has been seen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_chars_q <= 20'd0;
            slot_err_q   <= 4'd0;
            seen_q       <= 4'd0;
            chars        <= 20'd0;
            err          <= 4'd0;
            frame_valid  <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            if (capture) begin
                slot_chars_q <= slot_chars_d;
                slot_err_q   <= slot_err_d;
                if (seen_next == 4'hF) begin
                    chars       <= slot_chars_d;
                    err         <= slot_err_d;
                    frame_valid <= 1'b1;
                    seen_q      <= 4'd0;
                end else begin
                    seen_q <= seen_next;
                end
            end
        end
    end

endmodule
